// File: rtl/dual_port_ram_ext_if.sv
// Bus bundle for dual_port_ram_ext: both access ports plus init/collision status.
// The slave modport is the RAM side; master is the requester side.
interface dual_port_ram_ext_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10
);
  localparam int unsigned NumBytes = DATA_WIDTH / 8;

  logic                  init_done;
  logic                  en_a;
  logic                  we_a;
  logic [NumBytes-1:0]   be_a;
  logic [ADDR_WIDTH-1:0] addr_a;
  logic [DATA_WIDTH-1:0] din_a;
  logic [DATA_WIDTH-1:0] dout_a;
  logic                  valid_a;
  logic                  en_b;
  logic                  we_b;
  logic [NumBytes-1:0]   be_b;
  logic [ADDR_WIDTH-1:0] addr_b;
  logic [DATA_WIDTH-1:0] din_b;
  logic [DATA_WIDTH-1:0] dout_b;
  logic                  valid_b;
  logic                  collision;

  modport master (
    input  init_done, dout_a, valid_a, dout_b, valid_b, collision,
    output en_a, we_a, be_a, addr_a, din_a, en_b, we_b, be_b, addr_b, din_b
  );

  modport slave (
    output init_done, dout_a, valid_a, dout_b, valid_b, collision,
    input  en_a, we_a, be_a, addr_a, din_a, en_b, we_b, be_b, addr_b, din_b
  );
endinterface

// File: rtl/dual_port_ram_ext.sv
// True dual-port RAM with byte enables, read-during-write mode, 1/2-cycle read latency,
// cross-port collision flagging (port A wins) and a post-reset zeroing engine.
module dual_port_ram_ext #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned RD_LATENCY     = 1,
  parameter int unsigned WRITE_MODE     = 0,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input logic               clk,
  input logic               reset_n,
  dual_port_ram_ext_if.slave bus
);
  localparam int unsigned NumBytes = DATA_WIDTH / 8;
  localparam int unsigned Depth    = 2 ** ADDR_WIDTH;

  typedef enum logic {StClear, StReady} state_e;

  state_e                r_state, w_state_next;
  logic [ADDR_WIDTH-1:0] r_clr_addr;
  logic                  w_clr_we;
  logic [DATA_WIDTH-1:0] r_mem [Depth];

  logic                  w_init_done;
  logic                  w_acc_a, w_acc_b, w_wr_a, w_wr_b, w_same, w_col;
  logic [DATA_WIDTH-1:0] w_old_a, w_old_b, w_rd_a, w_rd_b;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= StClear;
      r_clr_addr <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_clr_we) r_clr_addr <= r_clr_addr + 1'b1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_clr_we     = 1'b0;
    unique case (r_state)
      StClear: begin
        if (CLEAR_ON_RESET != 0) begin
          w_clr_we = 1'b1;
          if (r_clr_addr == '1) w_state_next = StReady;
        end else begin
          w_state_next = StReady;
        end
      end
      StReady: w_state_next = StReady;
    endcase
  end

  assign w_init_done   = (r_state == StReady);
  assign bus.init_done = w_init_done;

  // A write with no byte enabled is treated as a plain read.
  assign w_acc_a = w_init_done & bus.en_a;
  assign w_acc_b = w_init_done & bus.en_b;
  assign w_wr_a  = w_acc_a & bus.we_a & (|bus.be_a);
  assign w_wr_b  = w_acc_b & bus.we_b & (|bus.be_b);
  assign w_same  = (bus.addr_a == bus.addr_b);
  assign w_col   = w_acc_a & w_acc_b & w_same & (w_wr_a | w_wr_b);

  // Array has no reset; clear writes never coincide with port writes.
  always_ff @(posedge clk) begin
    if (w_clr_we) r_mem[r_clr_addr] <= '0;
    for (int i = 0; i < NumBytes; i++) begin
      if (w_wr_b && bus.be_b[i] && !(w_same && w_wr_a && bus.be_a[i])) begin
        r_mem[bus.addr_b][8*i +: 8] <= bus.din_b[8*i +: 8];
      end
      if (w_wr_a && bus.be_a[i]) begin
        r_mem[bus.addr_a][8*i +: 8] <= bus.din_a[8*i +: 8];
      end
    end
  end

  // Write-first merges only this port's own bytes; the other port's write is never seen.
  always_comb begin
    w_old_a = r_mem[bus.addr_a];
    w_old_b = r_mem[bus.addr_b];
    w_rd_a  = w_old_a;
    w_rd_b  = w_old_b;
    if ((WRITE_MODE != 0) && w_wr_a) begin
      for (int i = 0; i < NumBytes; i++) begin
        if (bus.be_a[i]) w_rd_a[8*i +: 8] = bus.din_a[8*i +: 8];
      end
    end
    if ((WRITE_MODE != 0) && w_wr_b) begin
      for (int i = 0; i < NumBytes; i++) begin
        if (bus.be_b[i]) w_rd_b[8*i +: 8] = bus.din_b[8*i +: 8];
      end
    end
  end

  logic                  r_valid_a1, r_valid_b1, r_col1;
  logic [DATA_WIDTH-1:0] r_dout_a1, r_dout_b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid_a1 <= 1'b0;
      r_valid_b1 <= 1'b0;
      r_col1     <= 1'b0;
      r_dout_a1  <= '0;
      r_dout_b1  <= '0;
    end else begin
      r_valid_a1 <= w_acc_a;
      r_valid_b1 <= w_acc_b;
      r_col1     <= w_col;
      if (w_acc_a) r_dout_a1 <= w_rd_a;
      if (w_acc_b) r_dout_b1 <= w_rd_b;
    end
  end

  if (RD_LATENCY == 2) begin : g_lat2
    logic                  r_valid_a2, r_valid_b2, r_col2;
    logic [DATA_WIDTH-1:0] r_dout_a2, r_dout_b2;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_valid_a2 <= 1'b0;
        r_valid_b2 <= 1'b0;
        r_col2     <= 1'b0;
        r_dout_a2  <= '0;
        r_dout_b2  <= '0;
      end else begin
        r_valid_a2 <= r_valid_a1;
        r_valid_b2 <= r_valid_b1;
        r_col2     <= r_col1;
        if (r_valid_a1) r_dout_a2 <= r_dout_a1;
        if (r_valid_b1) r_dout_b2 <= r_dout_b1;
      end
    end

    assign bus.valid_a   = r_valid_a2;
    assign bus.valid_b   = r_valid_b2;
    assign bus.dout_a    = r_dout_a2;
    assign bus.dout_b    = r_dout_b2;
    assign bus.collision = r_col2;
  end else begin : g_lat1
    assign bus.valid_a   = r_valid_a1;
    assign bus.valid_b   = r_valid_b1;
    assign bus.dout_a    = r_dout_a1;
    assign bus.dout_b    = r_dout_b1;
    assign bus.collision = r_col1;
  end
endmodule

// File: tb/tb_dual_port_ram_ext.sv
// Two RAM instances (read-first/latency 1 and write-first/latency 2) share one stimulus
// stream; a word-array model feeds per-port expectation queues drained by a monitor.
module tb_dual_port_ram_ext;
  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 16;

  typedef struct {
    logic [31:0] data;
    logic        col;
    int          cyc;
  } exp_t;

  logic clk;
  logic reset_n;
  int   cyc = 0;
  int   rel_edges;
  int   n_cmp = 0;
  int   n_bad = 0;

  exp_t        q [4][$];
  logic [31:0] last [4];
  logic [31:0] mdl [DEPTH];

  dual_port_ram_ext_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if0 ();
  dual_port_ram_ext_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if1 ();

  dual_port_ram_ext #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(1), .WRITE_MODE(0), .CLEAR_ON_RESET(1)
  ) u_dut0 (
    .clk(clk), .reset_n(reset_n), .bus(if0.slave)
  );

  dual_port_ram_ext #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(2), .WRITE_MODE(1), .CLEAR_ON_RESET(1)
  ) u_dut1 (
    .clk(clk), .reset_n(reset_n), .bus(if1.slave)
  );

  assign if1.en_a   = if0.en_a;
  assign if1.we_a   = if0.we_a;
  assign if1.be_a   = if0.be_a;
  assign if1.addr_a = if0.addr_a;
  assign if1.din_a  = if0.din_a;
  assign if1.en_b   = if0.en_b;
  assign if1.we_b   = if0.we_b;
  assign if1.be_b   = if0.be_b;
  assign if1.addr_b = if0.addr_b;
  assign if1.din_b  = if0.din_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Edges seen since reset release; the RAM is ready once DEPTH of them have passed.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) rel_edges <= 0;
    else          rel_edges <= rel_edges + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h want %h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? n[8*i +: 8] : o[8*i +: 8];
    return r;
  endfunction

  task automatic mon_port(input int k, input string nm, input logic v, input logic [31:0] d,
                          input logic c);
    exp_t e;
    logic have;
    while (q[k].size() > 0 && q[k][0].cyc < cyc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s missing valid: got none want %h due cycle %0d", nm, q[k][0].data,
               q[k][0].cyc);
      void'(q[k].pop_front());
    end
    have = (q[k].size() > 0) && (q[k][0].cyc == cyc);
    chk({nm, " valid"}, {31'd0, v}, {31'd0, have});
    if (have) begin
      e = q[k].pop_front();
      last[k] = e.data;
      if (v) begin
        chk({nm, " dout"}, d, e.data);
        chk({nm, " collision"}, {31'd0, c}, {31'd0, e.col});
      end
    end else begin
      chk({nm, " dout hold"}, d, last[k]);
      chk({nm, " collision idle"}, {31'd0, c}, 32'd0);
    end
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      chk("rst init_done0", {31'd0, if0.init_done}, 32'd0);
      chk("rst init_done1", {31'd0, if1.init_done}, 32'd0);
      chk("rst valid0", {30'd0, if0.valid_a, if0.valid_b}, 32'd0);
      chk("rst valid1", {30'd0, if1.valid_a, if1.valid_b}, 32'd0);
      chk("rst dout0", if0.dout_a | if0.dout_b, 32'd0);
      chk("rst dout1", if1.dout_a | if1.dout_b, 32'd0);
      chk("rst collision", {30'd0, if0.collision, if1.collision}, 32'd0);
      for (int k = 0; k < 4; k++) begin
        last[k] = '0;
        q[k].delete();
      end
    end else begin
      chk("init_done0", {31'd0, if0.init_done}, {31'd0, rel_edges >= DEPTH});
      chk("init_done1", {31'd0, if1.init_done}, {31'd0, rel_edges >= DEPTH});
      mon_port(0, "d0_a", if0.valid_a, if0.dout_a, if0.collision);
      mon_port(1, "d0_b", if0.valid_b, if0.dout_b, if0.collision);
      mon_port(2, "d1_a", if1.valid_a, if1.dout_a, if1.collision);
      mon_port(3, "d1_b", if1.valid_b, if1.dout_b, if1.collision);
    end
  end

  // One request per port, sampled at the next rising edge; expectations pushed now.
  task automatic issue(input logic ea, input logic wa, input logic [3:0] ba,
                       input logic [3:0] aa, input logic [31:0] da,
                       input logic eb, input logic wb, input logic [3:0] bb,
                       input logic [3:0] ab, input logic [31:0] db);
    logic        ready, acca, accb, wra, wrb, col;
    logic [31:0] olda, oldb;
    @(negedge clk);
    if0.en_a = ea; if0.we_a = wa; if0.be_a = ba; if0.addr_a = aa; if0.din_a = da;
    if0.en_b = eb; if0.we_b = wb; if0.be_b = bb; if0.addr_b = ab; if0.din_b = db;
    ready = (rel_edges >= DEPTH);
    acca  = ready && ea;
    accb  = ready && eb;
    wra   = acca && wa && (ba != 4'd0);
    wrb   = accb && wb && (bb != 4'd0);
    olda  = mdl[aa];
    oldb  = mdl[ab];
    col   = acca && accb && (aa == ab) && (wra || wrb);
    if (acca) begin
      q[0].push_back('{data: olda, col: col, cyc: cyc + 1});
      q[2].push_back('{data: wra ? merge(olda, da, ba) : olda, col: col, cyc: cyc + 2});
    end
    if (accb) begin
      q[1].push_back('{data: oldb, col: col, cyc: cyc + 1});
      q[3].push_back('{data: wrb ? merge(oldb, db, bb) : oldb, col: col, cyc: cyc + 2});
    end
    // Port A applied last so it owns bytes both ports enable.
    if (wrb) mdl[ab] = merge(mdl[ab], db, bb);
    if (wra) mdl[aa] = merge(mdl[aa], da, ba);
  endtask

  task automatic idle();
    issue(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
  endtask

  task automatic rand_issue();
    logic [3:0] aa = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'($urandom_range(0, 2));
    logic [3:0] ab = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'($urandom_range(0, 2));
    issue($urandom_range(0, 3) != 0, 1'($urandom), 4'($urandom), aa, $urandom,
          $urandom_range(0, 3) != 0, 1'($urandom), 4'($urandom), ab, $urandom);
  endtask

  initial begin
    reset_n = 1'b0;
    if0.en_a = 0; if0.we_a = 0; if0.be_a = 0; if0.addr_a = 0; if0.din_a = 0;
    if0.en_b = 0; if0.we_b = 0; if0.be_b = 0; if0.addr_b = 0; if0.din_b = 0;
    for (int k = 0; k < 4; k++) last[k] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;

    // Traffic during clear must be dropped; abort the clear half way.
    while (rel_edges < 8) rand_issue();
    idle();
    @(posedge clk);
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;

    while (rel_edges < DEPTH + 2) rand_issue();

    for (int i = 0; i < DEPTH; i++) begin
      issue(1'b1, 1'b0, 4'h0, 4'(i), 32'h0, 1'b1, 1'b0, 4'h0, 4'(DEPTH - 1 - i), 32'h0);
    end

    issue(1'b1, 1'b1, 4'hF, 4'd5, 32'hAABBCCDD, 1'b0, 1'b0, 4'h0, 4'd0, 32'h0);
    issue(1'b1, 1'b1, 4'b0101, 4'd5, 32'h11223344, 1'b0, 1'b0, 4'h0, 4'd0, 32'h0);
    issue(1'b0, 1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 1'b0, 4'h0, 4'd5, 32'h0);

    issue(1'b1, 1'b1, 4'hF, 4'd3, 32'h12345678, 1'b0, 1'b0, 4'h0, 4'd0, 32'h0);
    issue(1'b1, 1'b1, 4'h0, 4'd3, 32'hDEADBEEF, 1'b0, 1'b0, 4'h0, 4'd0, 32'h0);

    issue(1'b1, 1'b1, 4'b1100, 4'd7, 32'hFFFF0000, 1'b1, 1'b1, 4'b0110, 4'd7, 32'h00FF00FF);
    issue(1'b1, 1'b0, 4'h0, 4'd7, 32'h0, 1'b0, 1'b0, 4'h0, 4'd0, 32'h0);

    issue(1'b0, 1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 1'b1, 4'hF, 4'd9, 32'h5);
    issue(1'b1, 1'b0, 4'h0, 4'd9, 32'h0, 1'b1, 1'b1, 4'hF, 4'd9, 32'h6);
    issue(1'b1, 1'b0, 4'h0, 4'd9, 32'h0, 1'b1, 1'b0, 4'h0, 4'd9, 32'h0);
    idle();

    repeat (600) rand_issue();
    repeat (4) idle();

    for (int k = 0; k < 4; k++) chk("queue drained", 32'(q[k].size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dual_port_ram_ext.md
# dual_port_ram_ext

Parametrised true dual-port synchronous RAM, next generation of the team's basic dual-port RAM. Adds per-port enables, byte-write enables, selectable read-during-write mode, 1- or 2-cycle read latency with a valid strobe, cross-port collision detection with fixed priority, and a post-reset clear engine that zeroes the array before accepting traffic. It serves as the shared buffer between two independent masters (e.g. processor bus and video/DMA engine) in the same clock domain.

## Interface
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8
- ADDR_WIDTH, 10, address bits; depth = 2**ADDR_WIDTH
- RD_LATENCY, 1, read latency in cycles; legal values 1 or 2
- WRITE_MODE, 0, same-port read-during-write: 0 = read-first (old data), 1 = write-first (new data)
- CLEAR_ON_RESET, 1, 1 = zero the whole array after reset release; 0 = skip

- clk  in  1  clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- init_done  out  1  high when the RAM accepts accesses
- en_a  in  1  port A access request
- we_a  in  1  port A write (qualified by en_a)
- be_a  in  DATA_WIDTH/8  port A byte enables, bit i covers din_a[8i+7:8i]
- addr_a  in  ADDR_WIDTH  port A address
- din_a  in  DATA_WIDTH  port A write data
- dout_a  out  DATA_WIDTH  port A read data
- valid_a  out  1  one-cycle strobe, dout_a carries the result of an access
- en_b, we_b, be_b, addr_b, din_b, dout_b, valid_b: identical to port A for port B
- collision  out  1  one-cycle strobe flagging a same-address cross-port conflict

## Operation
- Clear FSM states: CLEAR, READY. Reset forces CLEAR, counter = 0, init_done = 0.
- CLEAR (CLEAR_ON_RESET=1): writes 0 to address counter each cycle, counter +1; after writing address 2**ADDR_WIDTH-1 go to READY. Port requests ignored (no write, no valid, no collision).
- CLEAR_ON_RESET=0: first edge after reset release goes to READY; array contents undefined.
- READY: init_done = 1; stays until reset. Reset mid-clear restarts at address 0.
- Array contents never reset asynchronously; only control/output registers.
- Access accepted when init_done & en_x. Write (we_x=1) updates only bytes with be_x[i]=1; we_x=1 with be_x=0 is a read.
- Every accepted access (read or write) returns the word at addr_x on dout_x with valid_x.
- Same-port write data returned: WRITE_MODE 0 = pre-write word; 1 = merged word (enabled bytes new, others old).
- Cross-port same address, same cycle, both accepted, at least one writing: collision = 1 (RD_LATENCY cycles later, aligned with valid).
  - Both write: bytes enabled on both take port A data; other enabled bytes take their own port's data.
  - Cross-port read of the other port's write always returns pre-write data, regardless of WRITE_MODE.
- Outputs: dout_x holds last value when no access; valid_x and collision low otherwise.

## Timing
- Reset values: init_done 0, dout_a/dout_b 0, valid_a/valid_b 0, collision 0, FSM CLEAR, counter 0.
- Clear takes exactly 2**ADDR_WIDTH cycles; init_done rises on the edge writing the last address.
- Request sampled at edge t; RD_LATENCY=1: dout/valid/collision registered at edge t; RD_LATENCY=2: at edge t+1. Fully pipelined, one access per port per cycle.
- Requests during the cycle init_done is low are dropped, even if it rises at that edge.

## Test plan
- Reset release, CLEAR_ON_RESET=1, ADDR_WIDTH=4: init_done rises after exactly 16 cycles; read of every address returns 0x00000000; requests during clear produce no valid_a/valid_b.
- Byte write: addr 5 holds 0xAABBCCDD, port A writes 0x11223344 with be=4'b0101 -> subsequent read on port B returns 0xAA22CC44.
- Read-during-write addr 3 old 0x0, write 0x12345678 be=4'hF: WRITE_MODE 0 -> dout_a = 0x00000000; WRITE_MODE 1 -> 0x12345678; valid_a after 1 edge (RD_LATENCY=1) or 2 edges (RD_LATENCY=2).
- Dual write collision addr 7: A writes 0xFFFF0000 be=4'b1100, B writes 0x00FF00FF be=4'b0110 -> word 0xFFFF00xx with byte0 unchanged, byte1 = 0x00 (B), bytes 2-3 = 0xFF (A); collision=1 for one cycle aligned with valid.
- Cross-port read/write addr 9 old 0x5: A reads, B writes 0x6 -> dout_a = 0x5, collision=1; next cycle A reads 0x6, collision=0.
- Reset asserted at clear counter 8: all outputs 0 immediately; after release, clear restarts at address 0 and init_done rises after full 2**ADDR_WIDTH cycles.
